// File: rtl/cp_dma_stream_if.sv
// Memory-bus and block-core signals of the DMA stream engine, grouped for the
// engine (master) and the memory/core side (slave).
interface cp_dma_stream_if #(
  parameter int WPB    = 4,
  parameter int ADDR_W = 20
);
  // Handshakes: HOLD is a level request held until the engine is done with the
  // bus; a transfer only counts in a cycle where HOLD_ACK is sampled high.
  // core_start and core_done are single-cycle pulses qualifying core_din and
  // core_dout respectively; no back-pressure exists on either pulse.
  logic                  we_dma;
  logic [ADDR_W-1:0]     addr_dma;
  logic [31:0]           wrData_dma;
  logic [31:0]           rdData_dma;
  logic                  HOLD;
  logic                  HOLD_ACK;
  logic                  core_start;
  logic [31:0]           core_cfg;
  logic [WPB*32-1:0]     core_din;
  logic                  core_done;
  logic [WPB*32-1:0]     core_dout;

  modport master (
    output we_dma, addr_dma, rdData_dma, HOLD, core_start, core_cfg, core_din,
    input  wrData_dma, HOLD_ACK, core_done, core_dout
  );

  modport slave (
    input  we_dma, addr_dma, rdData_dma, HOLD, core_start, core_cfg, core_din,
    output wrData_dma, HOLD_ACK, core_done, core_dout
  );
endinterface

// File: rtl/cp_dma_stream.sv
// CPU-programmed block-stream DMA: reads LEN words block by block, runs each
// block through an attached core, and writes the results to a destination.
module cp_dma_stream #(
  parameter int WPB    = 4,
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        we_cpu,
  input  logic [2:0]  addr_cpu,
  input  logic [31:0] wrData_cpu,
  output logic [31:0] rdData_cpu,
  output logic        INT,
  output logic [3:0]  dbg_state,
  cp_dma_stream_if.master bus
);
  localparam int IW = $clog2(WPB + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_REQ_RD    = 4'd1;
  localparam logic [3:0] S_RD_ADDR   = 4'd2;
  localparam logic [3:0] S_RD_DATA   = 4'd3;
  localparam logic [3:0] S_CORE_GO   = 4'd4;
  localparam logic [3:0] S_CORE_WAIT = 4'd5;
  localparam logic [3:0] S_REQ_WR    = 4'd6;
  localparam logic [3:0] S_WR        = 4'd7;
  localparam logic [3:0] S_NEXT      = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  logic [3:0]        state;
  logic [ADDR_W-1:0] src_q, dst_q, src_ptr, dst_ptr;
  logic [LEN_W-1:0]  len_q, rem;
  logic [31:0]       cfg_q;
  logic              wb_full, int_en, done, aborted;
  logic [IW-1:0]     blk_idx, wr_idx, wr_cnt;
  logic [WPB*32-1:0] blk_q, res_q;
  logic              busy, ctrl_we, go_req, abort_req;
  logic [31:0]       status;

  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign ctrl_we   = we_cpu && (addr_cpu == 3'd0);
  assign go_req    = ctrl_we && wrData_cpu[0] && !wrData_cpu[1];
  assign abort_req = ctrl_we && wrData_cpu[1];

  assign INT          = done & int_en;
  assign dbg_state    = state;
  assign bus.core_cfg = cfg_q;
  assign bus.core_din = blk_q;

  always_comb begin
    status     = '0;
    status[2]  = wb_full;
    status[3]  = int_en;
    status[8]  = busy;
    status[9]  = bus.HOLD;
    status[10] = done;
    status[11] = aborted;
  end

  always_comb begin
    rdData_cpu = '0;
    case (addr_cpu)
      3'd0: rdData_cpu = status;
      3'd1: rdData_cpu[ADDR_W-1:0] = src_q;
      3'd2: rdData_cpu[ADDR_W-1:0] = dst_q;
      3'd3: rdData_cpu[LEN_W-1:0] = len_q;
      3'd4: rdData_cpu = cfg_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      src_q          <= '0;
      dst_q          <= '0;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      len_q          <= '0;
      rem            <= '0;
      cfg_q          <= '0;
      wb_full        <= 1'b0;
      int_en         <= 1'b0;
      done           <= 1'b0;
      aborted        <= 1'b0;
      blk_idx        <= '0;
      wr_idx         <= '0;
      wr_cnt         <= '0;
      blk_q          <= '0;
      res_q          <= '0;
      bus.we_dma     <= 1'b0;
      bus.addr_dma   <= '0;
      bus.rdData_dma <= '0;
      bus.HOLD       <= 1'b0;
      bus.core_start <= 1'b0;
    end else begin
      bus.core_start <= 1'b0;

      if (we_cpu && !busy) begin
        case (addr_cpu)
          3'd1: src_q <= {wrData_cpu[ADDR_W-1:2], 2'b00};
          3'd2: dst_q <= {wrData_cpu[ADDR_W-1:2], 2'b00};
          3'd3: len_q <= wrData_cpu[LEN_W-1:0];
          3'd4: cfg_q <= wrData_cpu;
          default: ;
        endcase
      end
      if (ctrl_we) begin
        int_en <= wrData_cpu[3];
        if (!busy) wb_full <= wrData_cpu[2];
        if (wrData_cpu[10]) begin
          done    <= 1'b0;
          aborted <= 1'b0;
        end
      end

      case (state)
        S_REQ_RD, S_RD_ADDR: begin
          if (bus.HOLD_ACK) begin
            bus.addr_dma <= src_ptr;
            state        <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          // A lost grant falls back to RD_ADDR so the same address is re-issued.
          if (bus.HOLD_ACK) begin
            blk_q[int'(blk_idx)*32 +: 32] <= bus.wrData_dma;
            src_ptr <= src_ptr + ADDR_W'(4);
            rem     <= rem - LEN_W'(1);
            blk_idx <= blk_idx + IW'(1);
            if (blk_idx == IW'(WPB - 1) || rem == LEN_W'(1)) begin
              state          <= S_CORE_GO;
              bus.HOLD       <= 1'b0;
              bus.core_start <= 1'b1;
            end else begin
              state <= S_RD_ADDR;
            end
          end else begin
            state <= S_RD_ADDR;
          end
        end
        S_CORE_GO: state <= S_CORE_WAIT;
        S_CORE_WAIT: begin
          if (bus.core_done) begin
            res_q    <= bus.core_dout;
            bus.HOLD <= 1'b1;
            wr_idx   <= '0;
            wr_cnt   <= wb_full ? IW'(WPB) : blk_idx;
            state    <= S_REQ_WR;
          end
        end
        S_REQ_WR, S_WR: begin
          bus.we_dma <= 1'b0;
          if (bus.HOLD_ACK) begin
            bus.we_dma     <= 1'b1;
            bus.addr_dma   <= dst_ptr;
            bus.rdData_dma <= res_q[int'(wr_idx)*32 +: 32];
            dst_ptr        <= dst_ptr + ADDR_W'(4);
            wr_idx         <= wr_idx + IW'(1);
            state          <= (wr_idx == wr_cnt - IW'(1)) ? S_NEXT : S_WR;
          end
        end
        S_NEXT: begin
          bus.we_dma <= 1'b0;
          if (rem != '0) begin
            blk_q   <= '0;
            blk_idx <= '0;
            state   <= S_REQ_RD;
          end else begin
            bus.HOLD <= 1'b0;
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (go_req && !busy) begin
        done    <= 1'b0;
        aborted <= 1'b0;
        src_ptr <= src_q;
        dst_ptr <= dst_q;
        rem     <= len_q;
        if (len_q == '0) begin
          done  <= 1'b1;
          state <= S_DONE;
        end else begin
          blk_q    <= '0;
          blk_idx  <= '0;
          bus.HOLD <= 1'b1;
          state    <= S_REQ_RD;
        end
      end

      // Abort drops everything at once; a core_done arriving later meets IDLE.
      if (abort_req && busy) begin
        state          <= S_IDLE;
        bus.HOLD       <= 1'b0;
        bus.we_dma     <= 1'b0;
        bus.core_start <= 1'b0;
        aborted        <= 1'b1;
        done           <= 1'b1;
      end
    end
  end
endmodule

// File: doc/cp_dma_stream.md
# cp_dma_stream

Parametrised successor to the co-processor DMA wrapper: a CPU-programmed block-stream engine sitting in a co-processor slot of the Main module. It pulls LEN words from external memory over the HOLD/HOLD_ACK bus, feeds them one WPB-word block at a time to an attached block core (AES or other), and writes each result block to a separate destination address. HOLD is released while the core computes. The block supports abort and two write-back modes, and raises INT on completion.

## Interface
- WPB, 4, words per block (1..8); core data buses are WPB*32 bits
- ADDR_W, 20, external memory byte-address width
- LEN_W, 16, length field width (words)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- we_cpu  in  1  CPU register write strobe
- addr_cpu  in  3  register select
- wrData_cpu  in  32  CPU write data
- rdData_cpu  out  32  register read data, combinational from addr_cpu
- we_dma  out  1  memory write enable (registered)
- addr_dma  out  ADDR_W  memory byte address (registered, bits[1:0]=0)
- wrData_dma  in  32  memory read data, valid the cycle after addr_dma is driven with we_dma=0
- rdData_dma  out  32  memory write data (registered with we_dma)
- HOLD  out  1  bus request
- HOLD_ACK  in  1  bus grant
- INT  out  1  done & int_en
- core_start  out  1  one-cycle pulse; core_din/core_cfg valid
- core_cfg  out  32  copy of CFG register
- core_din  out  WPB*32  block to core, word 0 in bits [31:0]
- core_done  in  1  one-cycle pulse; core_dout valid
- core_dout  in  WPB*32  result block

## Operation
- Registers: 0 CTRL/STATUS, 1 SRC, 2 DST, 3 LEN (words, LEN_W bits, upper bits read 0), 4 CFG; 5..7 read 0, writes ignored.
- CTRL write bits: [0] go (self-clearing), [1] abort (self-clearing), [2] wb_full, [3] int_en, [10] write 1 clears done and aborted.
- STATUS read: [2] wb_full, [3] int_en, [8] busy, [9] HOLD, [10] done, [11] aborted; all other bits 0.
- Writes to SRC/DST/LEN/CFG/wb_full while busy are ignored; go while busy is ignored; abort and go in the same write: abort wins.
- go with LEN=0: done=1 next cycle, HOLD never asserted.
- States: IDLE -> REQ_RD (HOLD=1, wait HOLD_ACK) -> RD_ADDR/RD_DATA per word -> CORE_GO (HOLD=0, core_start) -> CORE_WAIT (until core_done) -> REQ_WR (HOLD=1) -> WR per word -> NEXT (more words: REQ_RD, else DONE) -> DONE (HOLD=0, done=1, busy=0) -> IDLE.
- Reads: 2 cycles per word; words beyond remaining count in the last block are not read and are zero-padded in core_din.
- Write-back: wb_full=1 writes all WPB words of every block; wb_full=0 writes only valid words of the last block.
- SRC/DST pointers advance +4 per word, wrap modulo 2^ADDR_W.
- HOLD_ACK low during RD_* or WR: stall, we_dma=0, counters frozen; on regrant re-issue current word address.
- Abort in any state: next cycle IDLE, HOLD=0, we_dma=0, core_start=0, aborted=1, done=1; a later core_done is ignored.

## Timing
- Reset: all registers 0, state IDLE; we_dma=0, addr_dma=0, rdData_dma=0, HOLD=0, INT=0, core_start=0, core_din=0, core_cfg=0.
- go write in cycle 0 -> HOLD=1 after edge 1 (busy=1 same edge).
- Grant sampled high in cycle n -> first addr_dma driven edge n+1, data captured edge n+2.
- Last read capture -> core_start high the next cycle, HOLD low the same cycle.
- core_done in cycle m -> HOLD=1 after edge m+1; first we_dma one cycle after grant; one word per cycle.
- Block cost without wait states: 2 (arb) + 2*WPB + 1 + core latency + 2 + WPB cycles.
- Last write -> done=1 and INT (if int_en) next cycle.

## Test plan
- WPB=4, LEN=8, SRC=0x100, DST=0x200, HOLD_ACK tied high, core = inverter -> 8 writes of ~mem[0x100..0x11C] to 0x200..0x21C, two core_start pulses, done=1, INT=1.
- LEN=5, wb_full=0 -> 2nd core_din = {0,0,0,mem[0x110]}; exactly 5 writes; with wb_full=1, 8 writes.
- HOLD_ACK dropped 3 cycles mid-read of word 2 -> same result as scenario 1, no address skipped, we_dma never high while HOLD_ACK=0.
- abort written during CORE_WAIT -> next cycle HOLD=0, aborted=1, busy=0; late core_done causes no writes; CTRL bit 10 write clears done/aborted.
- go with LEN=0 -> done=1 after 1 cycle, HOLD stays 0; SRC write while busy leaves SRC unchanged.
- SRC=0xFFFF8, LEN=4 -> reads 0xFFFF8, 0xFFFFC, 0x00000, 0x00004; reset_n pulsed low mid-write -> all outputs 0 immediately.
